sd_sector_writer: RTL and testbench

- Consumes bytes from the UART receive FIFO path and writes them to the SD card as one 512-byte single-block write (CMD24) over SPI.
- Sits downstream of fifo_control and alongside sd_top.
- Runs only after sd_top reports init_ok.
- Its SPI pins go to the SD pin mux, which selects this block when init_ok=1.

---
 rtl/sd_sector_writer_if.sv | 28 ++
 rtl/sd_sector_writer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sd_sector_writer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_writer_if.sv
// Host-side signal bundle for sd_sector_writer: start/status, FIFO byte
// handshake and the SPI pins toward the SD pin mux.
interface sd_sector_writer_if;
    logic        init_ok;
    logic        wr_start;
    logic [31:0] wr_addr;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        sd_ck;
    logic        sd_mosi;
    logic        sd_csn;
    logic        sd_miso;
    logic        wr_busy;
    logic        wr_done;
    logic        wr_err;
    logic [1:0]  err_code;

    modport master (
        output init_ok, wr_start, wr_addr, din, din_valid, sd_miso,
        input  din_ready, sd_ck, sd_mosi, sd_csn, wr_busy, wr_done, wr_err, err_code
    );

    modport slave (
        input  init_ok, wr_start, wr_addr, din, din_valid, sd_miso,
        output din_ready, sd_ck, sd_mosi, sd_csn, wr_busy, wr_done, wr_err, err_code
    );
endinterface

// File: rtl/sd_sector_writer.sv
// Single-block (CMD24) SD write over SPI mode 0: command, R1 poll, token,
// 512 FIFO bytes, dummy CRC, data response, busy wait, 8 trailing clocks.
module sd_sector_writer #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned R1_POLL   = 8,
    parameter int unsigned BUSY_POLL = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    sd_sector_writer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_RESP, S_GAP, S_TOKEN,
        S_DATA, S_CRC, S_DRESP, S_BUSY, S_TAIL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [31:0] poll_q, poll_d;
    logic        eng_q, eng_d;
    logic [3:0]  half_q, half_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        csn_q, csn_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic        tick;
    logic        byte_done;
    logic        load;
    logic [7:0]  ld_byte;
    logic        go_tail;
    logic [1:0]  tail_code;

    assign tick      = eng_q && (div_q == 16'(CLK_DIV - 1));
    assign byte_done = tick && (half_q == 4'd15);

    // Byte engine, sequencer and output registers: next-state logic.
    // The engine is reloaded in the same cycle it finishes, so back-to-back
    // bytes run with no idle clock; load overrides the engine's stop.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        eng_d     = eng_q;
        half_d    = half_q;
        div_d     = div_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        csn_d     = csn_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        code_d    = code_q;
        load      = 1'b0;
        ld_byte   = 8'hFF;
        go_tail   = 1'b0;
        tail_code = 2'd0;

        if (eng_q) begin
            div_d = tick ? '0 : div_q + 16'd1;
            if (tick) begin
                half_d = half_q + 4'd1;
                if (!half_q[0]) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[6:0], bus.sd_miso};
                end else begin
                    sck_d = 1'b0;
                    if (half_q == 4'd15) begin
                        eng_d  = 1'b0;
                        mosi_d = 1'b1;
                    end else begin
                        mosi_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b1};
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                csn_d = 1'b1;
                if (bus.wr_start && bus.init_ok) begin
                    state_d = S_CMD;
                    addr_d  = bus.wr_addr;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                    csn_d   = 1'b0;
                    cnt_d   = 10'd1;
                    load    = 1'b1;
                    ld_byte = 8'h58;
                end
            end
            S_CMD: if (byte_done) begin
                load = 1'b1;
                if (cnt_q == 10'd6) begin
                    state_d = S_RESP;
                    poll_d  = 32'd1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                    case (cnt_q[2:0])
                        3'd1:    ld_byte = addr_q[31:24];
                        3'd2:    ld_byte = addr_q[23:16];
                        3'd3:    ld_byte = addr_q[15:8];
                        3'd4:    ld_byte = addr_q[7:0];
                        default: ld_byte = 8'hFF;
                    endcase
                end
            end
            S_RESP: if (byte_done) begin
                if (rx_q == 8'h00) begin
                    state_d = S_GAP;
                    load    = 1'b1;
                end else if (rx_q == 8'hFF && poll_q < 32'(R1_POLL)) begin
                    poll_d = poll_q + 32'd1;
                    load   = 1'b1;
                end else begin
                    go_tail   = 1'b1;
                    tail_code = 2'd1;
                end
            end
            S_GAP: if (byte_done) begin
                state_d = S_TOKEN;
                load    = 1'b1;
                ld_byte = 8'hFE;
            end
            S_TOKEN: if (byte_done) begin
                state_d = S_DATA;
                cnt_d   = '0;
                ready_d = 1'b1;
            end
            S_DATA: begin
                if (ready_q && bus.din_valid) begin
                    ready_d = 1'b0;
                    load    = 1'b1;
                    ld_byte = bus.din;
                end
                if (byte_done) begin
                    if (cnt_q == 10'd511) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 10'd1;
                        ready_d = 1'b1;
                    end
                end
            end
            S_CRC: if (byte_done) begin
                load = 1'b1;
                if (cnt_q == 10'd0) begin
                    cnt_d = 10'd1;
                end else begin
                    state_d = S_DRESP;
                end
            end
            S_DRESP: if (byte_done) begin
                if (rx_q[4:0] == 5'h05) begin
                    state_d = S_BUSY;
                    poll_d  = 32'd1;
                    load    = 1'b1;
                end else begin
                    go_tail   = 1'b1;
                    tail_code = 2'd2;
                end
            end
            S_BUSY: if (byte_done) begin
                if (rx_q == 8'hFF) begin
                    go_tail   = 1'b1;
                    tail_code = 2'd0;
                end else if (poll_q < 32'(BUSY_POLL)) begin
                    poll_d = poll_q + 32'd1;
                    load   = 1'b1;
                end else begin
                    go_tail   = 1'b1;
                    tail_code = 2'd3;
                end
            end
            S_TAIL: if (byte_done) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = (code_q != 2'd0);
            end
            default: state_d = S_IDLE;
        endcase

        if (go_tail) begin
            state_d = S_TAIL;
            code_d  = tail_code;
            csn_d   = 1'b1;
            load    = 1'b1;
            ld_byte = 8'hFF;
        end

        if (load) begin
            eng_d  = 1'b1;
            half_d = '0;
            div_d  = '0;
            sck_d  = 1'b0;
            mosi_d = ld_byte[7];
            tx_d   = {ld_byte[6:0], 1'b1};
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            poll_q  <= '0;
            eng_q   <= 1'b0;
            half_q  <= '0;
            div_q   <= '0;
            tx_q    <= '1;
            rx_q    <= '1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            csn_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
            eng_q   <= eng_d;
            half_q  <= half_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.sd_ck     = sck_q;
    assign bus.sd_mosi   = mosi_q;
    assign bus.sd_csn    = csn_q;
    assign bus.din_ready = ready_q;
    assign bus.wr_busy   = busy_q;
    assign bus.wr_done   = done_q;
    assign bus.wr_err    = err_q;
    assign bus.err_code  = code_q;

endmodule

// File: tb/tb_sd_sector_writer.sv
// Bench for sd_sector_writer: SPI card model plus a FIFO source; expected
// MOSI bytes are queued as stimulus is issued and matched as the card sees them.
module tb_sd_sector_writer;

    logic clk = 1'b0;
    logic rst_n;

    sd_sector_writer_if bus();

    sd_sector_writer #(
        .CLK_DIV  (1),
        .R1_POLL  (8),
        .BUSY_POLL(65535)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // card configuration (written by the stimulus process only)
    int         cfg_r1_at  = 1;
    logic [7:0] cfg_r1_val = 8'h00;
    logic [7:0] cfg_dresp  = 8'hE5;
    int         cfg_busy_n = 0;

    // card state (written by the card process only)
    typedef enum int {P_CMD, P_R1, P_TOK, P_DATA, P_CRC, P_DRESP, P_BUSY, P_IDLE} phase_t;
    phase_t     c_phase = P_CMD;
    int         c_cnt   = 0;
    int         c_gap   = 0;
    logic [2:0] c_bc    = 3'd0;
    logic [7:0] c_sh    = 8'h00;
    logic [7:0] c_resp  = 8'hFF;
    logic [7:0] got_mem [0:4095];
    int         wp      = 0;

    // stimulus / scoreboard state (written by the stimulus process only)
    logic [7:0] exp_q[$];
    int rp = 0;
    int hs_cnt = 0, idx = 0, stall_at = -1, stall_left = 0, din_upd = 0;
    int done_cnt = 0, done_base = 0, rdy_cnt = 0, rise_cnt = 0, rise_snap = 0;
    logic sck_prev = 1'b0;
    logic fifo_en  = 1'b0;

    assign bus.sd_miso = c_resp[3'd7 - c_bc];

    // SPI card model: shifts MOSI on sd_ck rise, presents the next MISO bit after it.
    always @(posedge bus.sd_ck or posedge bus.sd_csn) begin
        if (bus.sd_csn) begin
            c_phase = P_CMD;
            c_cnt   = 0;
            c_bc    = 3'd0;
            c_resp  = 8'hFF;
        end else begin
            c_sh = {c_sh[6:0], bus.sd_mosi};
            if (c_bc != 3'd7) begin
                c_bc = c_bc + 3'd1;
            end else begin
                c_bc = 3'd0;
                case (c_phase)
                    P_CMD: begin
                        got_mem[wp % 4096] = c_sh; wp++;
                        c_cnt++;
                        if (c_cnt == 6) begin c_phase = P_R1; c_cnt = 0; end
                    end
                    P_R1: begin
                        c_cnt++;
                        if (c_cnt == cfg_r1_at) begin
                            c_phase = (cfg_r1_val == 8'h00) ? P_TOK : P_IDLE;
                            c_gap   = 0;
                        end
                    end
                    P_TOK: begin
                        if (c_sh == 8'hFE) begin c_phase = P_DATA; c_cnt = 0; end
                        else c_gap++;
                    end
                    P_DATA: begin
                        got_mem[wp % 4096] = c_sh; wp++;
                        c_cnt++;
                        if (c_cnt == 512) begin c_phase = P_CRC; c_cnt = 0; end
                    end
                    P_CRC: begin
                        got_mem[wp % 4096] = c_sh; wp++;
                        c_cnt++;
                        if (c_cnt == 2) c_phase = P_DRESP;
                    end
                    P_DRESP: begin c_phase = P_BUSY; c_cnt = 0; end
                    P_BUSY:  c_cnt++;
                    default: ;
                endcase
                case (c_phase)
                    P_R1:    c_resp = (c_cnt == cfg_r1_at - 1) ? cfg_r1_val : 8'hFF;
                    P_DRESP: c_resp = cfg_dresp;
                    P_BUSY:  c_resp = (c_cnt < cfg_busy_n) ? 8'h00 : 8'hFF;
                    default: c_resp = 8'hFF;
                endcase
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock of bench activity, sampled at the falling edge.
    task automatic tick();
        logic [31:0] exp_b;
        @(negedge clk);
        while (rp != wp) begin
            if (exp_q.size() > 0) exp_b = {24'd0, exp_q.pop_front()};
            else exp_b = 32'h100;
            check_eq("mosi_byte", {24'd0, got_mem[rp % 4096]}, exp_b);
            rp++;
        end
        if (bus.wr_done) done_cnt++;
        if (bus.din_ready) rdy_cnt++;
        if (bus.sd_ck && !sck_prev) rise_cnt++;
        sck_prev = bus.sd_ck;
        if (din_upd != 0) begin
            din_upd = 0;
            bus.din = idx[7:0];
            if (idx == stall_at) begin
                bus.din_valid = 1'b0;
                stall_left    = 100;
            end
        end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 80) rise_snap = rise_cnt;
            if (stall_left == 0) begin
                check_eq("stall_no_sck", rise_cnt - rise_snap, 0);
                check_eq("stall_csn_low", bus.sd_csn, 0);
                check_eq("stall_ready", bus.din_ready, 1);
                bus.din_valid = fifo_en;
            end
        end
        if (fifo_en && bus.din_valid && bus.din_ready) begin
            exp_q.push_back(bus.din);
            hs_cnt++;
            idx++;
            din_upd = 1;
            if (idx == 512) begin
                exp_q.push_back(8'hFF);
                exp_q.push_back(8'hFF);
            end
        end
    endtask

    task automatic start_write(input logic [31:0] addr, input int r1_at, input logic [7:0] r1_val,
                               input logic [7:0] dresp, input int busy_n, input int stall);
        cfg_r1_at  = r1_at;
        cfg_r1_val = r1_val;
        cfg_dresp  = dresp;
        cfg_busy_n = busy_n;
        exp_q.delete();
        rp = wp;
        hs_cnt = 0; idx = 0; rdy_cnt = 0; din_upd = 0; stall_left = 0;
        stall_at  = stall;
        done_base = done_cnt;
        exp_q.push_back(8'h58);
        exp_q.push_back(addr[31:24]);
        exp_q.push_back(addr[23:16]);
        exp_q.push_back(addr[15:8]);
        exp_q.push_back(addr[7:0]);
        exp_q.push_back(8'hFF);
        bus.din       = 8'h00;
        bus.din_valid = 1'b1;
        fifo_en       = 1'b1;
        bus.wr_addr   = addr;
        bus.wr_start  = 1'b1;
        tick();
        bus.wr_start  = 1'b0;
        check_eq("busy_on_start", bus.wr_busy, 1);
        check_eq("err_clr_on_start", bus.wr_err, 0);
        check_eq("code_clr_on_start", bus.err_code, 0);
    endtask

    task automatic finish_write(input logic [1:0] exp_code, input int exp_hs);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            tick();
            if (bus.wr_done) seen = 1'b1;
        end
        check_eq("done_seen", seen, 1);
        check_eq("done_err", bus.wr_err, (exp_code != 2'd0));
        check_eq("done_code", bus.err_code, exp_code);
        check_eq("busy_drop_with_done", bus.wr_busy, 0);
        for (int i = 0; i < 20; i++) tick();
        check_eq("csn_after", bus.sd_csn, 1);
        check_eq("mosi_after", bus.sd_mosi, 1);
        check_eq("err_held", bus.err_code, exp_code);
        check_eq("handshakes", hs_cnt, exp_hs);
        check_eq("sb_leftover", exp_q.size(), 0);
        check_eq("done_pulses", done_cnt - done_base, 1);
        if (exp_code == 2'd1) check_eq("no_din_ready", rdy_cnt, 0);
        else check_eq("gap_len", c_gap, 1);
        fifo_en       = 1'b0;
        bus.din_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.init_ok   = 1'b1;
        bus.wr_start  = 1'b0;
        bus.wr_addr   = '0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        repeat (5) tick();
        check_eq("rst_ck", bus.sd_ck, 0);
        check_eq("rst_mosi", bus.sd_mosi, 1);
        check_eq("rst_csn", bus.sd_csn, 1);
        check_eq("rst_ready", bus.din_ready, 0);
        check_eq("rst_busy", bus.wr_busy, 0);
        check_eq("rst_done", bus.wr_done, 0);
        check_eq("rst_err", bus.wr_err, 0);
        check_eq("rst_code", bus.err_code, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // nominal write, R1 on second poll, three busy bytes
        start_write(32'h0000_0010, 2, 8'h00, 8'hE5, 3, -1);
        finish_write(2'd0, 512);

        // R1 never arrives
        start_write(32'h0000_0020, 100, 8'h00, 8'hE5, 0, -1);
        finish_write(2'd1, 0);

        // data rejected
        start_write(32'h0000_0030, 1, 8'h00, 8'h0B, 1, -1);
        finish_write(2'd2, 512);

        // FIFO stalls for 100 cycles before byte 300
        start_write(32'h1234_5678, 1, 8'h00, 8'hE5, 2, 300);
        finish_write(2'd0, 512);

        // start ignored without init_ok; second start and init_ok drop while busy
        bus.init_ok  = 1'b0;
        done_base    = done_cnt;
        bus.wr_start = 1'b1;
        tick();
        bus.wr_start = 1'b0;
        repeat (20) tick();
        check_eq("noinit_busy", bus.wr_busy, 0);
        check_eq("noinit_done", done_cnt - done_base, 0);
        check_eq("noinit_csn", bus.sd_csn, 1);
        bus.init_ok = 1'b1;
        start_write(32'hA5C3_0F01, 3, 8'h00, 8'hE5, 4, -1);
        repeat (50) tick();
        bus.init_ok  = 1'b0;
        bus.wr_addr  = 32'hDEAD_BEEF;
        bus.wr_start = 1'b1;
        tick();
        bus.wr_start = 1'b0;
        check_eq("busy_start_busy", bus.wr_busy, 1);
        finish_write(2'd0, 512);
        bus.init_ok = 1'b1;

        // reset in the middle of data byte 100
        start_write(32'h0000_0040, 1, 8'h00, 8'hE5, 1, -1);
        for (int i = 0; i < 20000 && hs_cnt < 101; i++) tick();
        check_eq("reached_byte100", hs_cnt, 101);
        repeat (5) tick();
        done_base = done_cnt;
        rst_n = 1'b0;
        tick();
        check_eq("midrst_csn", bus.sd_csn, 1);
        check_eq("midrst_ck", bus.sd_ck, 0);
        check_eq("midrst_mosi", bus.sd_mosi, 1);
        check_eq("midrst_ready", bus.din_ready, 0);
        check_eq("midrst_busy", bus.wr_busy, 0);
        fifo_en       = 1'b0;
        bus.din_valid = 1'b0;
        din_upd       = 0;
        exp_q.delete();
        rp = wp;
        rst_n = 1'b1;
        repeat (5) tick();
        check_eq("midrst_no_done", done_cnt - done_base, 0);
        start_write(32'h0000_0050, 2, 8'h00, 8'hE5, 2, -1);
        finish_write(2'd0, 512);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
